// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the pipelined dot-product block.
package pipe_pkg;

  localparam int DEF_LANES = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ACC_W = 80;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Exact width of a sum of `lanes` products of two `width`-bit operands.
  function automatic int sum_w(input int lanes, input int width);
    return 2 * width + clog2(lanes);
  endfunction

endpackage

// File: rtl/pipe_add_tree.sv
// S2 stage: sums all per-lane products into a full-precision registered total.
module pipe_add_tree
  import pipe_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  localparam int PROD_W = 2 * WIDTH,
  localparam int SUM_W  = sum_w(LANES, WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [LANES*PROD_W-1:0]   prod,
  output logic [SUM_W-1:0]          sum_q
);

  logic [SUM_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(prod[i*PROD_W +: PROD_W]);
    end
  end

  // NOTE: datapath registers are reset too, so result reads 0 straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else if (en) sum_q <= sum_d;
  end

endmodule

// File: rtl/pipe_dot_product.sv
// Three-stage unsigned dot product with valid/ready flow control.
// Define PIPE_DOT_ACC_EN to accumulate sums across a burst closed by in_last.
module pipe_dot_product
  import pipe_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ACC_W-1:0]       result,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = sum_w(LANES, WIDTH);

  logic                    stall;
  logic [LANES*PROD_W-1:0] s1_prod_d, s1_prod_q;
  logic                    s1_valid_d, s1_valid_q;
  logic                    s2_valid_d, s2_valid_q;
  logic [SUM_W-1:0]        s2_sum;
  logic [ACC_W-1:0]        result_d, result_q;
  logic                    out_valid_d, out_valid_q;

  // A held result blocks every stage, so back-pressure reaches the input in zero cycles.
  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s1_prod_d  = s1_prod_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          s1_prod_d[i*PROD_W +: PROD_W] =
            PROD_W'(a[i*WIDTH +: WIDTH]) * PROD_W'(b[i*WIDTH +: WIDTH]);
        end
      end
    end
  end

  pipe_add_tree #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_add_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall && s1_valid_q),
    .prod  (s1_prod_q),
    .sum_q (s2_sum)
  );

`ifdef PIPE_DOT_ACC_EN
  logic             s1_last_d, s1_last_q;
  logic             s2_last_d, s2_last_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0] total;

  always_comb begin
    s1_last_d   = s1_last_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    total       = acc_q + ACC_W'(s2_sum);
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      s1_last_d   = in_last;
      s2_last_d   = s1_last_q;
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          result_d    = total;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = total;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_last_q <= 1'b0;
      s2_last_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      s1_last_q <= s1_last_d;
      s2_last_q <= s2_last_d;
      acc_q     <= acc_d;
    end
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;

  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) result_d = ACC_W'(s2_sum);
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_prod_q   <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_prod_q   <= s1_prod_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pipe_dot_product.sv
// Self-checking bench for pipe_dot_product (LANES=2, WIDTH=32, ACC_W=80).
module tb_pipe_dot_product;

  localparam int LANES = 2;
  localparam int WIDTH = 32;
  localparam int ACC_W = 80;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [LANES*WIDTH-1:0] a, b;
  logic                   in_valid, in_last, in_ready;
  logic [ACC_W-1:0]       result;
  logic                   out_valid, out_ready;

  always #5 clk = ~clk;

  pipe_dot_product #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [79:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  logic [79:0] exp_q[$];
  logic [79:0] acc_m    = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [79:0] dot(input logic [63:0] av, input logic [63:0] bv);
    return 80'(av[31:0]) * 80'(bv[31:0]) + 80'(av[63:32]) * 80'(bv[63:32]);
  endfunction

  // Reference: one result per beat, or one per burst total when accumulating.
  function automatic void model_accept(input logic last, input logic [79:0] d);
`ifdef PIPE_DOT_ACC_EN
    acc_m = acc_m + d;
    if (last) begin
      exp_q.push_back(acc_m);
      acc_m = '0;
    end
`else
    exp_q.push_back(d);
`endif
  endfunction

  task automatic drive(input logic v, input logic l, input logic [63:0] av,
                       input logic [63:0] bv, input logic ordy);
    in_valid = v; in_last = l; a = av; b = bv; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  task automatic sb_cycle(input logic v, input logic l, input logic [63:0] av,
                          input logic [63:0] bv, input logic ordy,
                          input bit use_forced, input logic [79:0] forced);
    in_valid = v; in_last = l; a = av; b = bv; out_ready = ordy;
    #1;
    check("in_ready_rule", in_ready, !(out_valid && !ordy));
    if (out_valid && ordy) begin
      n_out++;
      if (exp_q.size() == 0) check("out_with_nothing_expected", out_valid, 1'b0);
      else check("result", result, exp_q.pop_front());
    end
    if (v && in_ready) model_accept(l, use_forced ? forced : dot(av, bv));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) sb_cycle(0, 0, '0, '0, 1, 0, '0);
    check("drain_empty", exp_q.size(), 0);
    drive(0, 0, '0, '0, 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   sent;
    int   outs_before;

    tbl[0] = '{64'h00000002_00000000, 64'h00000003_00000001, 80'd6};
    tbl[1] = '{64'h00000001_00000003, 64'h00000000_00000002, 80'd6};
    tbl[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 80'h1_FFFF_FFFC_0000_0002};
    tbl[3] = '{64'h00000005_00000007, 64'h0000000B_0000000D, 80'd146};
    tbl[4] = '{64'hFFFFFFFF_00000001, 64'h00000001_FFFFFFFF, 80'h1_FFFF_FFFE};
    tbl[5] = '{64'h12345678_00000000, 64'h00000000_9ABCDEF0, 80'd0};

    rst_n = 1'b0; in_valid = 0; in_last = 0; a = '0; b = '0; out_ready = 1;
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Two back-to-back beats of dot 6: exact latency and a two-cycle valid window.
    drive(1, 1, tbl[0].a, tbl[0].b, 1);
    check("lat_c1_valid", out_valid, 0);
    drive(1, 1, tbl[1].a, tbl[1].b, 1);
    check("lat_c2_valid", out_valid, 0);
    drive(0, 0, '0, '0, 1);
    check("lat_c3_valid", out_valid, 1);
    check("lat_c3_result", result, 6);
    drive(0, 0, '0, '0, 1);
    check("lat_c4_valid", out_valid, 1);
    check("lat_c4_result", result, 6);
    drive(0, 0, '0, '0, 1);
    check("lat_c5_valid", out_valid, 0);

    // Table vectors, one single-beat burst each.
    for (int i = 0; i < 6; i++) sb_cycle(1, 1, tbl[i].a, tbl[i].b, 1, 1, tbl[i].exp);
    drain();

    // Bubbles: beats on alternate cycles with dots 1, 2, 3.
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: drive(1, 1, 64'h00000000_00000001, 64'h00000000_00000001, 1);
        2: drive(1, 1, 64'h00000001_00000001, 64'h00000001_00000001, 1);
        4: drive(1, 1, 64'h00000001_00000002, 64'h00000001_00000001, 1);
        default: drive(0, 1, 64'hDEADBEEF_CAFEF00D, 64'hFFFFFFFF_FFFFFFFF, 1);
      endcase
      if ((k + 1) == 3 || (k + 1) == 5 || (k + 1) == 7) begin
        check("bubble_valid", out_valid, 1);
        check("bubble_result", result, 80'((k + 1 - 3) / 2 + 1));
      end else begin
        check("bubble_gap_valid", out_valid, 0);
      end
    end

    // Five-beat stream with the consumer stalled for cycles 4..6.
    sent = 0;
    for (int k = 0; k < 10; k++) begin
      logic ordy;
      logic [63:0] av;
      ordy = !(k >= 4 && k <= 6);
      out_ready = ordy;
      #1;
      check("stall_in_ready", in_ready, !(k >= 4 && k <= 6));
      av = {32'd1, 32'(sent + 1)};
      if (sent < 5) begin
        if (in_ready) sent++;
        sb_cycle(1, 1, av, 64'h00000003_00000002, ordy, 0, '0);
      end else begin
        sb_cycle(0, 0, '0, '0, ordy, 0, '0);
      end
    end
    check("stall_beats_sent", sent, 5);
    drain();

`ifdef PIPE_DOT_ACC_EN
    // Bursts: three beats of dot 6 give 18, then two beats give 12 from a fresh start.
    outs_before = n_out;
    sb_cycle(1, 0, tbl[0].a, tbl[0].b, 1, 0, '0);
    sb_cycle(1, 0, tbl[0].a, tbl[0].b, 1, 0, '0);
    sb_cycle(1, 1, tbl[0].a, tbl[0].b, 1, 0, '0);
    check("burst_expect_18", exp_q[0], 80'd18);
    drain();
    check("burst_single_output", n_out - outs_before, 1);
    sb_cycle(1, 0, tbl[1].a, tbl[1].b, 1, 0, '0);
    sb_cycle(1, 1, tbl[1].a, tbl[1].b, 1, 0, '0);
    drive(0, 0, '0, '0, 1);
    drive(0, 0, '0, '0, 1);
    check("burst2_valid", out_valid, 1);
    check("burst2_result", result, 80'd12);
    drain();
`else
    outs_before = n_out;
`endif

    // Reset with beats in flight.
    drive(1, 1, tbl[2].a, tbl[2].b, 1);
    drive(1, 1, tbl[3].a, tbl[3].b, 1);
    drive(1, 1, tbl[4].a, tbl[4].b, 1);
    check("pre_reset_valid", out_valid, 1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    acc_m = '0;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, '0, '0, 1);
      check("post_reset_no_stale", out_valid, 0);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      sb_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 9) < 7), 0, '0);
    end
    sb_cycle(1, 1, tbl[3].a, tbl[3].b, 1, 0, '0);
    while (!in_ready) sb_cycle(1, 1, tbl[3].a, tbl[3].b, 1, 0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Whole-run watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/pipe_dot_product.md
PIPE_DOT_PRODUCT -- requirements
Module: pipe_dot_product

Interface
REQ-001 SHALL have parameter LANES, default 2, number of multiply lanes (power of two, 1..16).
REQ-002 SHALL have parameter WIDTH, default 32, unsigned operand width per lane.
REQ-003 SHALL have parameter ACC_W, default 80, accumulator width; must be at least SUM_W.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 a  input  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH].
REQ-008 b  input  LANES*WIDTH  operand B, same packing as a.
REQ-009 in_valid  input  1  a/b/in_last valid this cycle.
REQ-010 in_last  input  1  final beat of an accumulation burst.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 result  output  ACC_W  dot product, or accumulated sum when accumulation is compiled in.
REQ-013 out_valid  output  1  result is valid.
REQ-014 out_ready  input  1  consumer accepts result this cycle.

Function
REQ-015 SHALL compute sum over i of a_i*b_i, unsigned; product width 2*WIDTH; SUM_W = 2*WIDTH+clog2(LANES); result zero-extended to ACC_W with no truncation.
REQ-016 SHALL be 3 stages: S1 registers per-lane products; S2 registers the adder-tree sum; S3 registers result and out_valid.
REQ-017 SHALL present result exactly 3 cycles after acceptance when out_ready is held high.
REQ-018 SHALL accept a beat when in_valid && in_ready; full throughput is 1 beat/cycle.
REQ-019 SHALL compute stall = out_valid && !out_ready; while stalled, all stages hold and in_ready = 0.
REQ-020 SHALL drive in_ready = !stall combinationally, with no dependence on in_valid.
REQ-021 SHALL keep result stable while out_valid && !out_ready.
REQ-022 SHALL propagate bubbles as stage valid bits = 0; a bubble never raises out_valid.
REQ-023 SHALL drop a beat when in_valid is low, regardless of a/b contents.

Reset
REQ-024 SHALL clear, on rst_n low, all stage valid bits, result = 0, out_valid = 0 and the accumulator = 0, immediately and asynchronously.
REQ-025 SHALL discard in-flight beats on reset mid-operation; in_ready = 1 at the first edge after release.

Configuration
REQ-026 With PIPE_DOT_ACC_EN defined, S3 SHALL add each S2 sum into the accumulator; out_valid only for an in_last beat, with result = the burst total; the accumulator restarts at 0 for the next beat; accumulator wraps modulo 2^ACC_W.
REQ-027 Without PIPE_DOT_ACC_EN, every accepted beat SHALL produce one result, in_last SHALL be ignored, and no accumulator register SHALL exist.

Structure
REQ-028 SHALL place the clog2 helper, the SUM_W derivation function and the default LANES/WIDTH/ACC_W constants in a shared package, pipe_pkg.
REQ-029 SHALL implement the registered S2 adder tree as sub-module pipe_add_tree, parameterised by LANES and WIDTH.

Verification
REQ-030 With LANES=2 and WIDTH=32, a={2,0}, b={3,1} (lane1,lane0), then a={1,3}, b={0,2} on the next cycle -> result 6 at cycles 3 and 4, out_valid high for 2 cycles.
REQ-031 With all operands 0xFFFFFFFF -> result 0x1_FFFF_FFFC_0000_0002, no overflow.
REQ-032 Stream of 5 beats with out_ready low for cycles 4-6 -> in_ready low for exactly those cycles, no beat lost or duplicated, outputs in order.
REQ-033 Assert rst_n low with 2 beats in flight -> out_valid = 0 immediately, no stale result after release.
REQ-034 With PIPE_DOT_ACC_EN defined, 3 beats each of dot 6 with in_last on the third -> a single out_valid with result 18; the next burst starts from 0.
REQ-035 in_valid toggling every other cycle with dot values 1, 2, 3 -> results 1, 2, 3 each 3 cycles after their beat, with bubbles between.
